axi2sram_slave: RTL and testbench

- AXI3-style slave that terminates the bus driven by the core's membus-to-AXI bridge and converts it into a single-port synchronous SRAM access.
- Serves one transaction at a time (read or write), supports FIXED and INCR bursts of up to 16 beats, and returns the transaction ID on B/R.
- Sits between the AXI interconnect (or the bridge directly) and the instruction/data SRAM macro.

---
 rtl/axi2sram_slave.sv | 197 +++++++++++++++++++
 tb/tb_axi2sram_slave.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi2sram_slave.sv
// rtl/axi2sram_slave.sv - AXI3 slave bridging one read or write burst at a time onto a single-port SRAM
module axi2sram_slave #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 6,
   parameter int STRB_WIDTH = DATA_WIDTH/8,
   parameter int SRAM_AW    = 14
) (
   input  logic                  ACLK,
   input  logic                  ARESETn,
   input  logic [ADDR_WIDTH-1:0] AWADDR,
   input  logic [3:0]            AWLEN,
   input  logic [2:0]            AWSIZE,
   input  logic [1:0]            AWBURST,
   input  logic [ID_WIDTH-1:0]   AWID,
   input  logic                  AWVALID,
   output logic                  AWREADY,
   input  logic [DATA_WIDTH-1:0] WDATA,
   input  logic [STRB_WIDTH-1:0] WSTRB,
   input  logic                  WLAST,
   input  logic [ID_WIDTH-1:0]   WID,
   input  logic                  WVALID,
   output logic                  WREADY,
   output logic [1:0]            BRESP,
   output logic [ID_WIDTH-1:0]   BID,
   output logic                  BVALID,
   input  logic                  BREADY,
   input  logic [ADDR_WIDTH-1:0] ARADDR,
   input  logic [3:0]            ARLEN,
   input  logic [2:0]            ARSIZE,
   input  logic [1:0]            ARBURST,
   input  logic [ID_WIDTH-1:0]   ARID,
   input  logic                  ARVALID,
   output logic                  ARREADY,
   output logic [DATA_WIDTH-1:0] RDATA,
   output logic [1:0]            RRESP,
   output logic                  RLAST,
   output logic [ID_WIDTH-1:0]   RID,
   output logic                  RVALID,
   input  logic                  RREADY,
   output logic                  sram_en,
   output logic                  sram_we,
   output logic [SRAM_AW-1:0]    sram_addr,
   output logic [DATA_WIDTH-1:0] sram_wdata,
   output logic [STRB_WIDTH-1:0] sram_wmask,
   input  logic [DATA_WIDTH-1:0] sram_rdata
);

   typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_REQ, RD_WAIT, RD_DATA} state_t;

   // Byte address kept only as wide as the SRAM span, so upper bits alias and bursts wrap.
   localparam int AQW = SRAM_AW + 2;

   state_t                state;
   logic [AQW-1:0]        addr_q;
   logic [AQW-1:0]        addr_next;
   logic [3:0]            len_q;
   logic [3:0]            cnt_q;
   logic [2:0]            size_q;
   logic [1:0]            burst_q;
   logic [ID_WIDTH-1:0]   id_q;
   logic                  err_q;
   logic                  prefer_wr;
   logic                  awready_q;
   logic                  arready_q;
   logic                  wready_q;
   logic                  bvalid_q;
   logic                  rvalid_q;
   logic                  rlast_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  w_hs;
   logic                  last_beat;
   logic                  unused_addr_hi;

   assign w_hs      = wready_q & WVALID;
   assign last_beat = (cnt_q == len_q);
   assign addr_next = (burst_q == 2'b00) ? addr_q : addr_q + (AQW'(1) << size_q);
   assign unused_addr_hi = ^{AWADDR[ADDR_WIDTH-1:AQW], ARADDR[ADDR_WIDTH-1:AQW]};

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state     <= IDLE;
         addr_q    <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         size_q    <= '0;
         burst_q   <= '0;
         id_q      <= '0;
         err_q     <= 1'b0;
         prefer_wr <= 1'b1;
         awready_q <= 1'b0;
         arready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rdata_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               // READY is raised a cycle after VALID is seen and lowered at the handshake edge.
               if (awready_q) begin
                  awready_q <= 1'b0;
                  if (AWVALID) begin
                     addr_q   <= AWADDR[AQW-1:0];
                     len_q    <= AWLEN;
                     size_q   <= AWSIZE;
                     burst_q  <= AWBURST;
                     id_q     <= AWID;
                     cnt_q    <= '0;
                     err_q    <= 1'b0;
                     wready_q <= 1'b1;
                     state    <= WR_DATA;
                  end
               end else if (arready_q) begin
                  arready_q <= 1'b0;
                  if (ARVALID) begin
                     addr_q  <= ARADDR[AQW-1:0];
                     len_q   <= ARLEN;
                     size_q  <= ARSIZE;
                     burst_q <= ARBURST;
                     id_q    <= ARID;
                     cnt_q   <= '0;
                     state   <= RD_REQ;
                  end
               end else if (AWVALID && (!ARVALID || prefer_wr)) begin
                  awready_q <= 1'b1;
                  prefer_wr <= 1'b0;
               end else if (ARVALID) begin
                  arready_q <= 1'b1;
                  prefer_wr <= 1'b1;
               end
            end
            WR_DATA: begin
               if (w_hs) begin
                  addr_q <= addr_next;
                  cnt_q  <= cnt_q + 4'd1;
                  if ((WID != id_q) || (WLAST != last_beat))
                     err_q <= 1'b1;
                  if (last_beat) begin
                     wready_q <= 1'b0;
                     bvalid_q <= 1'b1;
                     state    <= WR_RESP;
                  end
               end
            end
            WR_RESP: begin
               if (BREADY) begin
                  bvalid_q <= 1'b0;
                  state    <= IDLE;
               end
            end
            RD_REQ: state <= RD_WAIT;
            RD_WAIT: begin
               rdata_q  <= sram_rdata;
               rvalid_q <= 1'b1;
               rlast_q  <= last_beat;
               state    <= RD_DATA;
            end
            RD_DATA: begin
               if (RREADY) begin
                  rvalid_q <= 1'b0;
                  rlast_q  <= 1'b0;
                  if (last_beat) begin
                     state <= IDLE;
                  end else begin
                     cnt_q  <= cnt_q + 4'd1;
                     addr_q <= addr_next;
                     state  <= RD_REQ;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign AWREADY    = awready_q;
   assign ARREADY    = arready_q;
   assign WREADY     = wready_q;
   assign BVALID     = bvalid_q;
   assign BID        = id_q;
   assign BRESP      = {bvalid_q & err_q, 1'b0};
   assign RVALID     = rvalid_q;
   assign RID        = id_q;
   assign RRESP      = 2'b00;
   assign RLAST      = rlast_q;
   assign RDATA      = rdata_q;

   // Write beats go straight through to the SRAM in the cycle they are accepted.
   assign sram_en    = w_hs | (state == RD_REQ);
   assign sram_we    = w_hs;
   assign sram_addr  = addr_q[AQW-1:2];
   assign sram_wdata = WDATA;
   assign sram_wmask = w_hs ? WSTRB : '0;

endmodule

// File: tb/tb_axi2sram_slave.sv
// tb/tb_axi2sram_slave.sv - table-driven scoreboard bench for axi2sram_slave
`timescale 1ns/1ps
module tb_axi2sram_slave;

   logic        ACLK, ARESETn;
   logic [31:0] AWADDR, WDATA, ARADDR, RDATA, sram_wdata, sram_rdata;
   logic [3:0]  AWLEN, ARLEN, WSTRB, sram_wmask;
   logic [2:0]  AWSIZE, ARSIZE;
   logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
   logic [5:0]  AWID, WID, BID, ARID, RID;
   logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
   logic        ARVALID, ARREADY, RLAST, RVALID, RREADY, sram_en, sram_we;
   logic [13:0] sram_addr;

   axi2sram_slave dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWID(AWID),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WID(WID), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BID(BID), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARID(ARID),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RID(RID), .RVALID(RVALID), .RREADY(RREADY),
      .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
      .sram_wmask(sram_wmask), .sram_rdata(sram_rdata)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   // SRAM macro behaviour: read data appears the cycle after the enable.
   logic [31:0] mem [0:16383];
   always @(posedge ACLK) begin
      if (sram_en) begin
         if (sram_we) begin
            for (int b = 0; b < 4; b++)
               if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
         end else begin
            sram_rdata <= mem[sram_addr];
         end
      end
   end

   logic [31:0] ref_mem [0:16383];

   typedef struct { logic [31:0] data; logic last; logic [5:0] id; } rexp_t;
   rexp_t exp_q[$];

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [3:0]  len;
      logic [1:0]  burst;
      logic [5:0]  id;
      logic [31:0] data;
      logic [3:0]  strb;
      bit          stall;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl[13];

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // All bus tasks start and end 1ns after a rising edge.
   task automatic axi_write(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                            input logic [5:0] id, input logic [31:0] data0, input logic [3:0] strb,
                            input int last_at, input logic [1:0] exp_resp);
      logic [31:0] a;
      bit got;
      AWADDR = addr; AWLEN = len; AWSIZE = 3'd2; AWBURST = burst; AWID = id; AWVALID = 1'b1;
      got = 0;
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge ACLK);
         if (AWREADY) begin
            got = 1;
            check("aw_ar_exclusive", {31'd0, ARREADY}, 0);
         end
      end
      check("awready_seen", {63'd0, got}, 1);
      @(posedge ACLK); #1;
      AWVALID = 1'b0;
      if (!got) return;
      a = addr;
      for (int i = 0; i <= int'(len); i++) begin
         WDATA = data0 + i; WSTRB = strb; WID = id; WLAST = (i == last_at); WVALID = 1'b1;
         @(negedge ACLK);
         check("wr_en_we_wready", {61'd0, sram_en, sram_we, WREADY}, 3'b111);
         check("wr_sram_addr", {50'd0, sram_addr}, {50'd0, a[15:2]});
         check("wr_sram_wmask", {60'd0, sram_wmask}, {60'd0, strb});
         for (int b = 0; b < 4; b++)
            if (strb[b]) ref_mem[a[15:2]][8*b +: 8] = WDATA[8*b +: 8];
         @(posedge ACLK); #1;
         if (burst != 2'b00) a = a + 32'd4;
      end
      WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge ACLK);
         if (BVALID) got = 1;
      end
      check("bvalid_seen", {63'd0, got}, 1);
      check("bresp", {62'd0, BRESP}, {62'd0, exp_resp});
      check("bid", {58'd0, BID}, {58'd0, id});
      @(posedge ACLK); #1;
      BREADY = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                           input logic [5:0] id, input bit stall, output logic [31:0] first);
      logic [31:0] a;
      rexp_t e;
      bit got;
      int done;
      first = '0;
      a = addr;
      for (int i = 0; i <= int'(len); i++) begin
         e.data = ref_mem[a[15:2]]; e.last = (i == int'(len)); e.id = id;
         exp_q.push_back(e);
         if (burst != 2'b00) a = a + 32'd4;
      end
      ARADDR = addr; ARLEN = len; ARSIZE = 3'd2; ARBURST = burst; ARID = id; ARVALID = 1'b1;
      got = 0;
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge ACLK);
         if (ARREADY) begin
            got = 1;
            check("ar_aw_exclusive", {63'd0, AWREADY}, 0);
         end
      end
      check("arready_seen", {63'd0, got}, 1);
      @(posedge ACLK); #1;
      ARVALID = 1'b0;
      a = addr;
      done = 0;
      RREADY = !stall;
      for (int c = 0; c < 200 && done <= int'(len); c++) begin
         @(negedge ACLK);
         if (sram_en) begin
            check("rd_sram_we", {63'd0, sram_we}, 0);
            check("rd_sram_addr", {50'd0, sram_addr}, {50'd0, a[15:2]});
            if (burst != 2'b00) a = a + 32'd4;
         end
         if (RVALID) begin
            if (exp_q.size() == 0) begin
               check("rvalid_unexpected", {63'd0, RVALID}, 0);
            end else begin
               e = exp_q[0];
               check("rdata", {32'd0, RDATA}, {32'd0, e.data});
               check("rlast", {63'd0, RLAST}, {63'd0, e.last});
               check("rid", {58'd0, RID}, {58'd0, e.id});
               check("rresp", {62'd0, RRESP}, 0);
               if (RREADY) begin
                  if (done == 0) first = RDATA;
                  void'(exp_q.pop_front());
                  done++;
               end
            end
         end
         @(posedge ACLK); #1;
         if (stall) RREADY = !RREADY;
      end
      check("read_beats", done, int'(len) + 1);
      RREADY = 1'b0;
   endtask

   task automatic do_reset();
      ARESETn = 1'b0;
      repeat (2) @(posedge ACLK);
      #1;
      ARESETn = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] first;
      bit got;
      vec_t v;
      ARESETn = 1'b0;
      AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWID = '0; AWVALID = 1'b0;
      WDATA = '0; WSTRB = '0; WLAST = 1'b0; WID = '0; WVALID = 1'b0; BREADY = 1'b0;
      ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARID = '0; ARVALID = 1'b0; RREADY = 1'b0;
      for (int i = 0; i < 16384; i++) ref_mem[i] = '0;

      //          wr  addr          len   burst  id        data          strb  stall exp
      tbl[0]  = '{1, 32'h0000_0010, 4'd0, 2'b01, 6'b001001, 32'hDEADBEEF, 4'hF, 0, 32'h0};
      tbl[1]  = '{0, 32'h0000_0010, 4'd0, 2'b01, 6'b010001, 32'h0,        4'h0, 0, 32'hDEADBEEF};
      tbl[2]  = '{1, 32'h0000_0100, 4'd3, 2'b01, 6'h02,     32'h1,        4'hF, 0, 32'h0};
      tbl[3]  = '{0, 32'h0000_0100, 4'd3, 2'b01, 6'h03,     32'h0,        4'h0, 1, 32'h1};
      tbl[4]  = '{1, 32'h0000_0200, 4'd0, 2'b01, 6'h04,     32'h11223344, 4'hF, 0, 32'h0};
      tbl[5]  = '{1, 32'h0000_0200, 4'd0, 2'b01, 6'h05,     32'hAABBCCDD, 4'h5, 0, 32'h0};
      tbl[6]  = '{0, 32'h0000_0200, 4'd0, 2'b01, 6'h06,     32'h0,        4'h0, 0, 32'h11BB33DD};
      tbl[7]  = '{1, 32'h0000_003C, 4'd2, 2'b00, 6'h07,     32'h50,       4'hF, 0, 32'h0};
      tbl[8]  = '{0, 32'h0000_003C, 4'd1, 2'b00, 6'h08,     32'h0,        4'h0, 1, 32'h52};
      tbl[9]  = '{1, 32'h0001_0010, 4'd0, 2'b01, 6'h09,     32'hCAFEF00D, 4'hF, 0, 32'h0};
      tbl[10] = '{0, 32'h0000_0010, 4'd0, 2'b01, 6'h0A,     32'h0,        4'h0, 0, 32'hCAFEF00D};
      tbl[11] = '{1, 32'h0000_FFFC, 4'd1, 2'b01, 6'h0B,     32'h77,       4'hF, 0, 32'h0};
      tbl[12] = '{0, 32'h0000_0000, 4'd0, 2'b01, 6'h0C,     32'h0,        4'h0, 0, 32'h78};

      repeat (2) @(posedge ACLK);
      @(negedge ACLK);
      check("rst_ready_valid", {58'd0, AWREADY, ARREADY, WREADY, BVALID, RVALID, sram_en}, 0);
      check("rst_we_resp", {59'd0, sram_we, BRESP, RRESP}, 0);
      check("rst_rdata", {32'd0, RDATA}, 0);
      @(posedge ACLK); #1;
      ARESETn = 1'b1;

      // Single write then read-back with exact latency.
      axi_write(32'h10, 4'd0, 2'b01, 6'b001001, 32'hDEADBEEF, 4'hF, 0, 2'b00);
      ARADDR = 32'h10; ARLEN = 4'd0; ARSIZE = 3'd2; ARBURST = 2'b01; ARID = 6'b010001; ARVALID = 1'b1;
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge ACLK);
         if (ARREADY) got = 1;
      end
      check("lat_arready", {63'd0, got}, 1);
      @(posedge ACLK); #1;
      ARVALID = 1'b0;
      @(negedge ACLK);
      check("lat_c1_en_we_rvalid", {61'd0, sram_en, sram_we, RVALID}, 3'b100);
      check("lat_c1_addr", {50'd0, sram_addr}, 64'd4);
      @(negedge ACLK);
      check("lat_c2_rvalid", {63'd0, RVALID}, 0);
      @(negedge ACLK);
      check("lat_c3_rvalid_rlast", {62'd0, RVALID, RLAST}, 2'b11);
      check("lat_c3_rdata", {32'd0, RDATA}, 64'hDEADBEEF);
      check("lat_c3_rid", {58'd0, RID}, 64'b010001);
      @(posedge ACLK); #1;
      RREADY = 1'b1;
      @(negedge ACLK);
      check("lat_held_rvalid", {63'd0, RVALID}, 1);
      @(posedge ACLK); #1;
      RREADY = 1'b0;
      @(negedge ACLK);
      check("lat_done_rvalid", {63'd0, RVALID}, 0);
      @(posedge ACLK); #1;

      for (int i = 0; i < 13; i++) begin
         v = tbl[i];
         if (v.wr) begin
            axi_write(v.addr, v.len, v.burst, v.id, v.data, v.strb, int'(v.len), 2'b00);
         end else begin
            axi_read(v.addr, v.len, v.burst, v.id, v.stall, first);
            check($sformatf("vec%0d_first_rdata", i), {32'd0, first}, {32'd0, v.exp});
         end
      end

      // Contention from reset: write wins first, then the pending read; repeated.
      for (int k = 0; k < 2; k++) begin
         do_reset();
         ARADDR = 32'h100; ARLEN = 4'd0; ARSIZE = 3'd2; ARBURST = 2'b01; ARID = 6'h15; ARVALID = 1'b1;
         axi_write(32'h300, 4'd0, 2'b01, 6'h16, 32'h1234 + k, 4'hF, 0, 2'b00);
         axi_read(32'h100, 4'd0, 2'b01, 6'h15, 0, first);
         check("contention_read", {32'd0, first}, 64'h1);
      end

      // WLAST on the first beat of a two-beat write.
      axi_write(32'h400, 4'd1, 2'b01, 6'h0A, 32'h99, 4'hF, 0, 2'b10);

      // Reset while a read beat is being presented.
      ARADDR = 32'h100; ARLEN = 4'd3; ARSIZE = 3'd2; ARBURST = 2'b01; ARID = 6'h21; ARVALID = 1'b1;
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge ACLK);
         if (ARREADY) got = 1;
      end
      @(posedge ACLK); #1;
      ARVALID = 1'b0;
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge ACLK);
         if (RVALID) got = 1;
      end
      check("midburst_rvalid_seen", {63'd0, got}, 1);
      #1 ARESETn = 1'b0;
      #1;
      check("midburst_rst_rvalid", {63'd0, RVALID}, 0);
      check("midburst_rst_misc", {61'd0, AWREADY, ARREADY, sram_en}, 0);
      @(posedge ACLK); #1;
      ARESETn = 1'b1;
      exp_q.delete();
      axi_write(32'h500, 4'd0, 2'b01, 6'h22, 32'hA5A5_5A5A, 4'hF, 0, 2'b00);
      axi_read(32'h500, 4'd0, 2'b01, 6'h23, 0, first);
      check("post_reset_read", {32'd0, first}, 64'hA5A5_5A5A);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
